// File: rtl/chain_pkg.sv
// chain_pkg
// Shared types and constants for the chain relaxation sequencer.
//   FP_W / FP_FRAC / FP_ONE : Q16.16 fixed-point format description
//   state_e                 : sequencer FSM states
//   point_t                 : one chain point {x, y}
//   idx_width / cnt_width   : counter width helpers derived from chain length
package chain_pkg;

  localparam int FP_W    = 32;
  localparam int FP_FRAC = 16;
  localparam logic [FP_W-1:0] FP_ONE = FP_W'(1) << FP_FRAC;

  typedef enum logic [1:0] {
    IDLE,
    RELAX,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [FP_W-1:0] x;
    logic [FP_W-1:0] y;
  } point_t;

  // Width of a point index (0 .. n-1).
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width of the load counter, which must also hold the value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/chain_relax_sequencer_regfile.sv
// point_regfile
// Storage for the chain: N_POINTS x 64-bit points, not reset.
//   clk              : rising-edge clock
//   we_i/waddr_i/wdata_i : single synchronous write port
//   up/cur/down_addr_i -> up/cur/down_o : combinational kernel read ports
//   drain_addr_i -> drain_o             : combinational drain read port
module point_regfile
  import chain_pkg::*;
#(
  parameter int N_POINTS = 8,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  point_t           wdata_i,
  input  logic [IDX_W-1:0] up_addr_i,
  input  logic [IDX_W-1:0] cur_addr_i,
  input  logic [IDX_W-1:0] down_addr_i,
  input  logic [IDX_W-1:0] drain_addr_i,
  output point_t           up_o,
  output point_t           cur_o,
  output point_t           down_o,
  output point_t           drain_o
);

  point_t mem_q [N_POINTS];

  // Point storage is deliberately left unreset; contents are only
  // meaningful after a full load.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign up_o    = mem_q[up_addr_i];
  assign cur_o   = mem_q[cur_addr_i];
  assign down_o  = mem_q[down_addr_i];
  assign drain_o = mem_q[drain_addr_i];

endmodule

// File: rtl/chain_relax_sequencer.sv
// chain_relax_sequencer
// Loads a chain of N_POINTS Q16.16 points, sweeps it ITERS times in place
// (Gauss-Seidel) through an external combinational kernel, then streams it out.
//   clk, rst_n                    : clock, synchronous active-low reset
//   in_valid/in_ready, in_x/in_y  : point load stream (IDLE only)
//   start                         : run request, honoured once fully loaded
//   busy, done                    : busy in RELAX/DRAIN, done pulse at end of run
//   out_valid/out_ready, out_x/y  : relaxed point stream (DRAIN)
//   k_up_*, k_*, k_down_*, k_is_last : kernel operands (RELAX only, else 0)
//   k_x_new, k_y_new              : kernel result, written back to the current point
module chain_relax_sequencer
  import chain_pkg::*;
#(
  parameter int N_POINTS = 8,
  parameter int ITERS    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] k_up_x,
  output logic [31:0] k_up_y,
  output logic [31:0] k_x,
  output logic [31:0] k_y,
  output logic [31:0] k_down_x,
  output logic [31:0] k_down_y,
  output logic        k_is_last,
  input  logic [31:0] k_x_new,
  input  logic [31:0] k_y_new
);

  localparam int IDX_W  = idx_width(N_POINTS);
  localparam int CNT_W  = cnt_width(N_POINTS);
  localparam int ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(N_POINTS);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]    idx_q,      idx_d;
  logic [ITER_W-1:0]   iter_q,     iter_d;
  logic [IDX_W-1:0]    rd_q,       rd_d;
  logic                done_q,     done_d;

  logic                we;
  logic [IDX_W-1:0]    waddr;
  point_t              wdata;
  logic [IDX_W-1:0]    down_addr;
  logic                at_last;
  point_t              up_pt, cur_pt, down_pt, drain_pt;

  // At the last point the down neighbour aliases the current point, so the
  // down read port simply re-reads idx.
  assign at_last   = (idx_q == LAST_IDX);
  assign down_addr = at_last ? idx_q : idx_q + IDX_W'(1);

  point_regfile #(
    .N_POINTS (N_POINTS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk          (clk),
    .we_i         (we),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .up_addr_i    (idx_q - IDX_W'(1)),
    .cur_addr_i   (idx_q),
    .down_addr_i  (down_addr),
    .drain_addr_i (rd_q),
    .up_o         (up_pt),
    .cur_o        (cur_pt),
    .down_o       (down_pt),
    .drain_o      (drain_pt)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      load_cnt_q <= '0;
      idx_q      <= '0;
      iter_q     <= '0;
      rd_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      idx_q      <= idx_d;
      iter_q     <= iter_d;
      rd_q       <= rd_d;
      done_q     <= done_d;
    end
  end

  // Next-state, regfile write mux and output decode.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    idx_d      = idx_q;
    iter_d     = iter_q;
    rd_d       = rd_q;
    done_d     = 1'b0;

    we         = 1'b0;
    waddr      = idx_q;
    wdata      = '{x: k_x_new, y: k_y_new};

    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    out_x      = '0;
    out_y      = '0;
    k_up_x     = '0;
    k_up_y     = '0;
    k_x        = '0;
    k_y        = '0;
    k_down_x   = '0;
    k_down_y   = '0;
    k_is_last  = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = (load_cnt_q < FULL_CNT);
        if (in_valid && in_ready) begin
          we         = 1'b1;
          waddr      = load_cnt_q[IDX_W-1:0];
          wdata      = '{x: in_x, y: in_y};
          load_cnt_d = load_cnt_q + CNT_W'(1);
        end
        // Uses the registered count, so a start coinciding with the final
        // load is dropped rather than remembered.
        if (start && (load_cnt_q == FULL_CNT)) begin
          state_d = RELAX;
          idx_d   = IDX_W'(1);
          iter_d  = '0;
        end
      end

      RELAX: begin
        busy      = 1'b1;
        k_up_x    = up_pt.x;
        k_up_y    = up_pt.y;
        k_x       = cur_pt.x;
        k_y       = cur_pt.y;
        k_down_x  = down_pt.x;
        k_down_y  = down_pt.y;
        k_is_last = at_last;
        we        = 1'b1;
        waddr     = idx_q;
        if (at_last) begin
          if (iter_q == LAST_ITER) begin
            state_d = DRAIN;
            rd_d    = '0;
          end else begin
            idx_d  = IDX_W'(1);
            iter_d = iter_q + ITER_W'(1);
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_x     = drain_pt.x;
        out_y     = drain_pt.y;
        if (out_ready) begin
          if (rd_q == LAST_IDX) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            load_cnt_d = '0;
          end else begin
            rd_d = rd_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_chain_relax_sequencer.sv
// tb_chain_relax_sequencer
// Scoreboard bench: a behavioural chain model pushes the expected drained
// points when a run is started; an independent monitor pops and compares on
// every output handshake and also watches kernel operands and done.
module tb_chain_relax_sequencer;
  import chain_pkg::*;

  localparam int NP = 8;
  localparam int IT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_x, in_y;
  logic        start, busy, done;
  logic        out_valid, out_ready;
  logic [31:0] out_x, out_y;
  logic [31:0] k_up_x, k_up_y, k_x, k_y, k_down_x, k_down_y;
  logic        k_is_last;
  logic [31:0] k_x_new, k_y_new;

  int          errors = 0;
  int          checks = 0;
  int          kmode = 0;
  int          rdy_mode = 0;
  int          relax_cnt = 0;
  int          done_cnt = 0;
  logic        pending_done = 1'b0;
  logic [63:0] sb [$];
  logic [31:0] ldx [NP];
  logic [31:0] ldy [NP];

  always #5 clk = ~clk;

  chain_relax_sequencer #(.N_POINTS(NP), .ITERS(IT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .k_up_x    (k_up_x),
    .k_up_y    (k_up_y),
    .k_x       (k_x),
    .k_y       (k_y),
    .k_down_x  (k_down_x),
    .k_down_y  (k_down_y),
    .k_is_last (k_is_last),
    .k_x_new   (k_x_new),
    .k_y_new   (k_y_new)
  );

  // Kernel behaviours: 0 increment x, 1 copy-up, 2 neighbour mixing.
  function automatic logic [63:0] kern(input int mode,
                                       input logic [31:0] ux, uy, cx, cy, dx, dy,
                                       input logic last);
    case (mode)
      0:       return {cx + FP_ONE, cy};
      1:       return {ux, uy};
      default: return {ux + dx - cx + (last ? 32'h100 : 32'h0), cy ^ (ux >> 3)};
    endcase
  endfunction

  always_comb {k_x_new, k_y_new} = kern(kmode, k_up_x, k_up_y, k_x, k_y,
                                        k_down_x, k_down_y, k_is_last);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: sweep the loaded chain in plain loops and queue the result.
  task automatic buildExpected();
    logic [31:0] mx [NP];
    logic [31:0] my [NP];
    logic [63:0] r;
    int d;
    for (int i = 0; i < NP; i++) begin
      mx[i] = ldx[i];
      my[i] = ldy[i];
    end
    for (int it = 0; it < IT; it++) begin
      for (int i = 1; i < NP; i++) begin
        d = (i == NP - 1) ? i : i + 1;
        r = kern(kmode, mx[i-1], my[i-1], mx[i], my[i], mx[d], my[d], i == NP - 1);
        mx[i] = r[63:32];
        my[i] = r[31:0];
      end
    end
    for (int i = 0; i < NP; i++) sb.push_back({mx[i], my[i]});
  endtask

  // Downstream ready: always, 1-0-0-1 pattern, or random.
  initial begin
    int cyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
  end

  // Monitor: done timing, kernel operand shape during RELAX, output scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("done", {63'd0, done}, {63'd0, pending_done});
      if (pending_done) begin
        checkOutput("busy_at_done", {63'd0, busy}, 64'd0);
        done_cnt++;
      end
      pending_done = 1'b0;

      if (busy && !out_valid) begin
        automatic int idx = (relax_cnt % (NP - 1)) + 1;
        checkOutput("k_is_last", {63'd0, k_is_last}, {63'd0, idx == NP - 1});
        if (idx == NP - 1) begin
          checkOutput("k_down_eq_cur", {k_down_x, k_down_y}, {k_x, k_y});
        end
        relax_cnt++;
      end

      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got 0x%0h/0x%0h with empty scoreboard", out_x, out_y);
        end else begin
          checkOutput("out_x", {32'd0, out_x}, {32'd0, sb[0][63:32]});
          checkOutput("out_y", {32'd0, out_y}, {32'd0, sb[0][31:0]});
          if (out_ready) begin
            void'(sb.pop_front());
            if (sb.size() == 0) pending_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int first, input int last, input int start_at);
    for (int i = first; i <= last; i++) begin
      in_valid = 1'b1;
      in_x     = ldx[i];
      in_y     = ldy[i];
      start    = (i == start_at);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitRunEnd();
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < 500) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("[TB] FAIL run_timeout: got no done after %0d cycles, required done", n);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", 64'(done_cnt - base), 64'd1);
    checkOutput("relax_cycles", 64'(relax_cnt), 64'(IT * (NP - 1)));
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic fullRun(input int mode, input int rmode);
    kmode    = mode;
    rdy_mode = rmode;
    applyStimulus(0, NP - 1, -1);
    @(negedge clk);
    checkOutput("in_ready_full", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    buildExpected();
    relax_cnt = 0;
    pulseStart();
    waitRunEnd();
  endtask

  task automatic randomPoints();
    for (int i = 0; i < NP; i++) begin
      ldx[i] = $urandom;
      ldy[i] = $urandom;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    start    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out", {out_x, out_y}, 64'd0);
    checkOutput("rst_k", {k_up_x ^ k_x ^ k_down_x, k_up_y | k_y | k_down_y}, 64'd0);
    checkOutput("rst_k_is_last", {63'd0, k_is_last}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Increment kernel plus start qualification.
    kmode    = 0;
    rdy_mode = 0;
    for (int i = 0; i < NP; i++) begin
      ldx[i] = FP_ONE * 32'(i);
      ldy[i] = '0;
    end
    applyStimulus(0, 4, -1);
    pulseStart();
    @(negedge clk);
    checkOutput("start_early_busy", {63'd0, busy}, 64'd0);
    checkOutput("start_early_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(5, NP - 1, NP - 1);
    @(negedge clk);
    checkOutput("start_with_last_load", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("start_not_latched", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    buildExpected();
    relax_cnt = 0;
    pulseStart();
    @(negedge clk);
    checkOutput("start_honoured", {63'd0, busy}, 64'd1);
    waitRunEnd();

    // Copy-up kernel: anchor value must propagate to every point.
    randomPoints();
    ldx[0] = 32'h0005_0000;
    ldy[0] = 32'h0003_0000;
    fullRun(1, 1);

    // Mixing kernel with random data and random back-pressure.
    randomPoints();
    fullRun(2, 2);
    randomPoints();
    fullRun(2, 1);

    // Reset in the middle of RELAX.
    kmode = 2;
    randomPoints();
    applyStimulus(0, NP - 1, -1);
    relax_cnt = 0;
    pulseStart();
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst_out", {out_x, out_y}, 64'd0);
    checkOutput("midrst_k", {k_up_x | k_x | k_down_x, k_up_y | k_y | k_down_y}, 64'd0);
    checkOutput("midrst_k_is_last", {63'd0, k_is_last}, 64'd0);
    @(posedge clk);
    #1;
    randomPoints();
    fullRun(2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chain_relax_sequencer.md
# chain_relax_sequencer

Sequential driver for the combinational point-constraint kernel. Buffers a chain of N points in Q16.16 fixed point, sweeps the chain Gauss-Seidel style for a fixed number of iterations, and streams the relaxed chain out. Each sweep presents every movable point with its up and down neighbours to the kernel and writes the kernel result back in place. It sits between the point-load stream and the downstream renderer/consumer stream.

## Interface
- N_POINTS, 8: chain length; legal range 3..256.
- ITERS, 4: full sweeps per run; legal range ≥1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid / in_ready  in / out  1 / 1  load handshake.
- in_x, in_y  in  32 / 32  loaded point, Q16.16 two's complement.
- start  in  1  single-cycle run request.
- busy  out  1  high in RELAX and DRAIN.
- done  out  1  one-cycle pulse at end of run.
- out_valid / out_ready  out / in  1 / 1  result handshake.
- out_x, out_y  out  32 / 32  relaxed point.
- k_up_x, k_up_y, k_x, k_y, k_down_x, k_down_y  out  32 each  kernel operands.
- k_is_last  out  1  kernel last-point flag.
- k_x_new, k_y_new  in  32 / 32  kernel results; the kernel is purely combinational.

## Operation
- States: IDLE, RELAX, DRAIN.
- **IDLE**
  - `in_ready = (load_cnt < N_POINTS)`.
  - Each in handshake writes `pt[load_cnt]` and increments load_cnt.
  - start is honoured only when load_cnt == N_POINTS at the sampling edge; otherwise it is ignored, with no latching.
  - On a valid start: go to RELAX with idx = 1, iter = 0.
- **RELAX**, one point per cycle:
  - Kernel operands: up = `pt[idx-1]`, cur = `pt[idx]`.
  - down = `pt[idx+1]` when idx < N_POINTS-1. At idx == N_POINTS-1, down = cur and k_is_last = 1. k_is_last = 0 otherwise.
  - At the clock edge, `pt[idx]` is written with (k_x_new, k_y_new).
  - idx increments. When idx wraps from N_POINTS-1 back to 1, iter increments.
  - After the wrap in which iter reaches ITERS-1, go to DRAIN with rd = 0.
  - Point 0 is an anchor and is never written.
  - Updates are in place: point idx sees the updated idx-1 from the same sweep.
- **DRAIN**
  - `out_valid = 1`, `out_x/out_y = pt[rd]`.
  - On out handshake: rd increments.
  - On the handshake with rd == N_POINTS-1: go to IDLE, pulse done, clear load_cnt.
  - Output data is held stable while out_valid && !out_ready.
- Outside RELAX, kernel operand outputs drive 0 and k_is_last = 0.
- in_valid is ignored outside IDLE (in_ready = 0). start is ignored outside IDLE.
- No arithmetic is done in this block; all values pass through unmodified.

## Timing
- Reset values:
  - state IDLE; load_cnt, idx, iter, rd = 0.
  - in_ready = 1, busy = 0, done = 0, out_valid = 0.
  - out_x, out_y = 0; all k_* outputs = 0.
  - Point storage is not reset.
- Reset mid-run in any state returns to IDLE and discards loaded points (load_cnt = 0).
- Load: 1 point/cycle at full throughput.
- start → first RELAX cycle: next cycle.
- RELAX duration: exactly ITERS × (N_POINTS−1) cycles, independent of any stream.
- First out_valid appears the cycle after the last RELAX cycle.
- Drain takes N_POINTS handshakes.
- done is high in the cycle after the final out handshake, coincident with the first IDLE cycle. busy is 0 in that cycle.
- Simultaneous events:
  - start and the final load handshake in the same cycle: start is ignored, because load_cnt < N_POINTS when sampled.
  - start on the cycle after the final load is honoured.

## Structure
- Package `chain_pkg`:
  - FP_W = 32, FP_FRAC = 16, FP_ONE = 32'h0001_0000.
  - State enum {IDLE, RELAX, DRAIN}.
  - Point struct {x, y}.
  - Index width derived as `$clog2(N_POINTS)`.
- One sub-module, `point_regfile`:
  - N_POINTS × 64-bit register array.
  - Three combinational read ports (up, cur, down) plus one drain read port.
  - One synchronous write port, muxed between load and relax writes.
- FSM and counters live in the top.

## Test plan
- Increment kernel (k_x_new = k_x + FP_ONE, k_y_new = k_y), N=8, ITERS=4; load x = i·FP_ONE, y = 0 → drained x = 0, then (i+4)·FP_ONE for i = 1..7; y all 0; RELAX lasts exactly 28 cycles.
- Copy-up kernel (k_x_new = k_up_x, k_y_new = k_up_y), ITERS=1; point 0 = (5.0, 3.0), others distinct → every drained point equals (0x0005_0000, 0x0003_0000), proving in-place Gauss-Seidel order.
- Monitor kernel ports during RELAX → k_is_last = 1 only at idx 7, and then k_down equals k_x/k_y; point 0 never appears as cur.
- start after only 5 loads → no state change; 3 more loads, then start → run proceeds; start on the same cycle as the 8th load → ignored.
- out_ready toggled 1,0,0,1 pattern → no lost or duplicated points; out_x/out_y stable while stalled; done pulses exactly once, one cycle after the 8th handshake.
- rst_n low for one cycle mid-RELAX → IDLE next cycle, busy = 0, in_ready = 1, all outputs at reset values; a fresh load and run then completes correctly.
